// File: rtl/cpu_trace_pkg.sv
// Shared constants, types and the decimal-digit extractor for the CPU trace emitter.
// Define TRACE_NEWLINE_EN to append a line feed after each frame's '#'.
package cpu_trace_pkg;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_SPACE  = 8'h20;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_LT     = 8'h3C;
  localparam logic [7:0] CH_EQ     = 8'h3D;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_ZERO   = 8'h30;

  localparam logic [13:0] TIME_MAX = 14'd9999;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CARET,
    ST_TIME,
    ST_AT,
    ST_PC,
    ST_COLON,
    ST_SP1,
    ST_TAG,
    ST_ARG,
    ST_SP2,
    ST_LT,
    ST_EQ,
    ST_DATA,
`ifdef TRACE_NEWLINE_EN
    ST_HASH,
    ST_NL
`else
    ST_HASH
`endif
  } state_t;

`ifdef TRACE_NEWLINE_EN
  localparam state_t ST_LAST = ST_NL;
`else
  localparam state_t ST_LAST = ST_HASH;
`endif

  // Event fields captured at acceptance; stamp is already saturated.
  typedef struct packed {
    logic        kind;
    logic [13:0] stamp;
    logic [31:0] pc;
    logic [4:0]  rnum;
    logic [31:0] addr;
    logic [31:0] data;
  } event_t;

  typedef struct packed {
    state_t      state;
    logic [2:0]  idx;
    logic [13:0] rem;
  } step_t;

  typedef struct packed {
    logic [3:0]  digit;
    logic [13:0] rem;
  } dec_t;

  // Decimal place weight selected by digit index 0..3 (thousands..units).
  function automatic logic [13:0] dec_weight(input logic [2:0] idx);
    case (idx)
      3'd0:    return 14'd1000;
      3'd1:    return 14'd100;
      3'd2:    return 14'd10;
      default: return 14'd1;
    endcase
  endfunction

  // First digit index that skips leading zeros; zero still prints one digit.
  function automatic logic [2:0] dec_start(input logic [13:0] v);
    if (v >= 14'd1000) return 3'd0;
    if (v >= 14'd100)  return 3'd1;
    if (v >= 14'd10)   return 3'd2;
    return 3'd3;
  endfunction

  function automatic dec_t dec_digit(input logic [13:0] v, input logic [2:0] idx);
    dec_t        res;
    logic [13:0] w;
    w         = dec_weight(idx);
    res.rem   = v;
    res.digit = 4'd0;
    for (int k = 0; k < 9; k++) begin
      if (res.rem >= w) begin
        res.rem   = res.rem - w;
        res.digit = res.digit + 4'd1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cpu_trace_emitter_if.sv
// Event-in / character-out handshake bundle of the CPU trace emitter.
interface cpu_trace_emitter_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_kind;
  logic [13:0] req_time;
  logic [31:0] req_pc;
  logic [4:0]  req_reg;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [7:0]  char;
  logic        char_valid;
  logic        char_ready;

  modport master (
    output req_valid, req_kind, req_time, req_pc, req_reg, req_addr, req_data, char_ready,
    input  req_ready, char, char_valid
  );

  modport slave (
    input  req_valid, req_kind, req_time, req_pc, req_reg, req_addr, req_data, char_ready,
    output req_ready, char, char_valid
  );
endinterface

// File: rtl/cpu_trace_emitter_hex_ascii.sv
// Nibble to lowercase ASCII hex digit.
module trace_hex_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);
  assign ascii = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble})
                                  : (8'h57 + {4'h0, nibble});
endmodule

// File: rtl/cpu_trace_emitter.sv
// Serializes CPU write-back events into ASCII trace frames, one char per transfer.
// Define TRACE_NEWLINE_EN to end each frame with a line feed after '#'.
module cpu_trace_emitter
  import cpu_trace_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  cpu_trace_emitter_if.slave   bus,
  output logic [15:0]          frame_cnt
);

  state_t      state;
  logic [2:0]  idx;
  logic [13:0] dec_rem;
  event_t      ev;
  logic [7:0]  char_q;
  logic        char_valid_q;
  logic        ready_q;

  step_t       nxt;
  dec_t        dec;
  logic [31:0] hex_word;
  logic [3:0]  hex_nibble;
  logic [7:0]  hex_char;
  logic [7:0]  char_next;
  logic        accept;
  logic        xfer;

  assign accept = bus.req_valid && ready_q;
  assign xfer   = char_valid_q && bus.char_ready;

  assign bus.req_ready  = ready_q;
  assign bus.char       = char_q;
  assign bus.char_valid = char_valid_q;

  // Where the FSM goes after the current char is taken (or an event is accepted).
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    nxt = '{state: state, idx: idx, rem: dec_rem};
    case (state)
      ST_IDLE:  nxt = '{state: ST_CARET, idx: 3'd0, rem: dec_rem};
      ST_CARET: nxt = '{state: ST_TIME, idx: dec_start(ev.stamp), rem: ev.stamp};
      ST_TIME:  nxt = (idx == 3'd3) ? '{state: ST_AT, idx: 3'd0, rem: dec_rem}
                                    : '{state: ST_TIME, idx: idx + 3'd1, rem: dec_rem};
      ST_AT:    nxt = '{state: ST_PC, idx: 3'd0, rem: dec_rem};
      ST_PC:    nxt = (idx == 3'd7) ? '{state: ST_COLON, idx: 3'd0, rem: dec_rem}
                                    : '{state: ST_PC, idx: idx + 3'd1, rem: dec_rem};
      ST_COLON: nxt.state = ST_SP1;
      ST_SP1:   nxt.state = ST_TAG;
      ST_TAG:   nxt = ev.kind ? '{state: ST_ARG, idx: 3'd0, rem: dec_rem}
                              : '{state: ST_ARG, idx: dec_start({9'd0, ev.rnum}),
                                  rem: {9'd0, ev.rnum}};
      ST_ARG:   nxt = (idx == (ev.kind ? 3'd7 : 3'd3)) ? '{state: ST_SP2, idx: 3'd0, rem: dec_rem}
                                                       : '{state: ST_ARG, idx: idx + 3'd1, rem: dec_rem};
      ST_SP2:   nxt.state = ST_LT;
      ST_LT:    nxt.state = ST_EQ;
      ST_EQ:    nxt = '{state: ST_DATA, idx: 3'd0, rem: dec_rem};
      ST_DATA:  nxt = (idx == 3'd7) ? '{state: ST_HASH, idx: 3'd0, rem: dec_rem}
                                    : '{state: ST_DATA, idx: idx + 3'd1, rem: dec_rem};
`ifdef TRACE_NEWLINE_EN
      ST_HASH:  nxt = '{state: ST_NL, idx: 3'd0, rem: dec_rem};
      ST_NL:    nxt = '{state: ST_IDLE, idx: 3'd0, rem: dec_rem};
`else
      ST_HASH:  nxt = '{state: ST_IDLE, idx: 3'd0, rem: dec_rem};
`endif
      default:  nxt = '{state: ST_IDLE, idx: 3'd0, rem: 14'd0};
    endcase
  end

  // Single decimal extractor shared by TIME and the register number; its
  // remainder is kept in dec_rem for the following digit.
  assign dec = dec_digit(nxt.rem, nxt.idx);

  always_comb begin
    hex_word = ev.data;
    if (nxt.state == ST_PC)       hex_word = ev.pc;
    else if (nxt.state == ST_ARG) hex_word = ev.addr;
  end

  assign hex_nibble = hex_word[{~nxt.idx, 2'b00} +: 4];

  trace_hex_ascii u_hex (
    .nibble (hex_nibble),
    .ascii  (hex_char)
  );

  always_comb begin
    char_next = 8'h00;
    case (nxt.state)
      ST_CARET: char_next = CH_CARET;
      ST_TIME:  char_next = CH_ZERO + {4'h0, dec.digit};
      ST_AT:    char_next = CH_AT;
      ST_PC:    char_next = hex_char;
      ST_COLON: char_next = CH_COLON;
      ST_SP1:   char_next = CH_SPACE;
      ST_TAG:   char_next = ev.kind ? CH_STAR : CH_DOLLAR;
      ST_ARG:   char_next = ev.kind ? hex_char : (CH_ZERO + {4'h0, dec.digit});
      ST_SP2:   char_next = CH_SPACE;
      ST_LT:    char_next = CH_LT;
      ST_EQ:    char_next = CH_EQ;
      ST_DATA:  char_next = hex_char;
      ST_HASH:  char_next = CH_HASH;
`ifdef TRACE_NEWLINE_EN
      ST_NL:    char_next = CH_LF;
`endif
      default:  char_next = 8'h00;
    endcase
  end

  // Ready drops on acceptance and only returns once the frame is back in IDLE,
  // which leaves one idle cycle between back-to-back frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      idx          <= 3'd0;
      dec_rem      <= 14'd0;
      ev           <= '0;
      char_q       <= 8'h00;
      char_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      frame_cnt    <= 16'd0;
    end else if (accept || xfer) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state        <= nxt.state;
      idx          <= nxt.idx;
      dec_rem      <= dec.rem;
      char_q       <= char_next;
      char_valid_q <= (nxt.state != ST_IDLE);
      ready_q      <= (nxt.state == ST_IDLE);
      if (accept) begin
        ev.kind  <= bus.req_kind;
        ev.stamp <= (bus.req_time > TIME_MAX) ? TIME_MAX : bus.req_time;
        ev.pc    <= bus.req_pc;
        ev.rnum  <= bus.req_reg;
        ev.addr  <= bus.req_addr;
        ev.data  <= bus.req_data;
      end
      if (xfer && state == ST_LAST) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Directed self-checking bench for cpu_trace_emitter (follows TRACE_NEWLINE_EN if defined).
module tb_cpu_trace_emitter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] frame_cnt;
  int          n_checks = 0;
  int          n_pass   = 0;

  cpu_trace_emitter_if bus ();

  cpu_trace_emitter dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

`ifdef TRACE_NEWLINE_EN
  localparam logic [7:0] FINAL_CH = 8'h0A;
  localparam int         FRAME_EXTRA = 1;
`else
  localparam logic [7:0] FINAL_CH = 8'h23;
  localparam int         FRAME_EXTRA = 0;
`endif

  function automatic string fin(input string s);
`ifdef TRACE_NEWLINE_EN
    return {s, "\n"};
`else
    return s;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    n_checks++;
    assert (obs == exp) n_pass++;
    else $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
  endtask

  task automatic set_event(input logic kind, input logic [13:0] t, input logic [31:0] pc,
                           input logic [4:0] rn, input logic [31:0] addr, input logic [31:0] data);
    bus.req_kind = kind;
    bus.req_time = t;
    bus.req_pc   = pc;
    bus.req_reg  = rn;
    bus.req_addr = addr;
    bus.req_data = data;
  endtask

  // Offer the event at a negedge and return at the negedge after it was accepted.
  task automatic offer(input string tag);
    int waited = 0;
    bus.req_valid = 1'b1;
    while (!bus.req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_accept_in_time"}, 32'(waited < 50), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Drain one frame; optionally stall randomly and verify held chars.
  task automatic collect(input string tag, input bit rnd, output string got, output int span);
    int         cyc = 0;
    int         first = -1;
    int         last = 0;
    bit         done = 1'b0;
    bit         pend = 1'b0;
    logic [7:0] held = 8'h00;
    got = "";
    while (!done && cyc < 400) begin
      if (pend) begin
        check({tag, "_stall_valid"}, 32'(bus.char_valid), 32'd1);
        check({tag, "_stall_char"}, 32'(bus.char), 32'(held));
        pend = 1'b0;
      end
      bus.char_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.char_valid) begin
        if (first < 0) first = cyc;
        if (bus.char_ready) begin
          got  = $sformatf("%s%c", got, bus.char);
          last = cyc;
          if (bus.char == FINAL_CH) done = 1'b1;
        end else begin
          pend = 1'b1;
          held = bus.char;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.char_ready = 1'b1;
    check({tag, "_frame_done"}, 32'(done), 32'd1);
    span = last - first + 1;
  endtask

  initial begin
    string s1, s2, s3, s4, s5, got;
    int    span, cyc, cnt, hash_cyc, caret2_cyc, finals;

    s1 = fin("^2@000030f4: $31 <=12345678#");
    s2 = fin("^242@00003000: *0000001c <=00000abc#");
    s3 = fin("^0@00000010: $5 <=deadbeef#");
    s4 = fin("^9999@ffffffff: $0 <=00000000#");
    s5 = fin("^10@0a0b0c0d: $10 <=89abcdef#");

    reset = 1'b1;
    bus.req_valid  = 1'b0;
    bus.char_ready = 1'b1;
    set_event(1'b0, 14'd0, 32'd0, 5'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    check("in_reset_char_valid", 32'(bus.char_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_char_valid", 32'(bus.char_valid), 32'd0);
    check("rst_char", 32'(bus.char), 32'h00);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);

    // Register write, continuous ready: one char per cycle.
    set_event(1'b0, 14'd2, 32'h000030f4, 5'd31, 32'hffffffff, 32'h12345678);
    offer("f1");
    collect("f1", 1'b0, got, span);
    check_str("f1_text", got, s1);
    check("f1_span", 32'(span), 32'(28 + FRAME_EXTRA));
    check("f1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("f1_idle_valid", 32'(bus.char_valid), 32'd0);
    check("f1_idle_char", 32'(bus.char), 32'h00);

    set_event(1'b1, 14'd242, 32'h00003000, 5'd7, 32'h0000001c, 32'h00000abc);
    offer("f2");
    collect("f2", 1'b0, got, span);
    check_str("f2_text", got, s2);
    check("f2_span", 32'(span), 32'(36 + FRAME_EXTRA));

    set_event(1'b0, 14'd0, 32'h00000010, 5'd5, 32'h0, 32'hdeadbeef);
    offer("f3");
    collect("f3", 1'b0, got, span);
    check_str("f3_text", got, s3);

    set_event(1'b0, 14'd12000, 32'hffffffff, 5'd0, 32'h0, 32'h0);
    offer("f4");
    collect("f4", 1'b0, got, span);
    check_str("f4_text_sat", got, s4);

    set_event(1'b0, 14'd10, 32'h0a0b0c0d, 5'd10, 32'h0, 32'h89abcdef);
    offer("f5");
    collect("f5", 1'b0, got, span);
    check_str("f5_text", got, s5);
    check("f5_frame_cnt", 32'(frame_cnt), 32'd5);

    // Random back-pressure must not change the character stream.
    set_event(1'b0, 14'd2, 32'h000030f4, 5'd31, 32'h0, 32'h12345678);
    offer("r1");
    collect("r1", 1'b1, got, span);
    check_str("r1_text", got, s1);
    set_event(1'b1, 14'd242, 32'h00003000, 5'd0, 32'h0000001c, 32'h00000abc);
    offer("r2");
    collect("r2", 1'b1, got, span);
    check_str("r2_text", got, s2);
    check("r_frame_cnt", 32'(frame_cnt), 32'd7);

    // Back-to-back events with req_valid held high.
    set_event(1'b0, 14'd2, 32'h000030f4, 5'd31, 32'h0, 32'h12345678);
    bus.req_valid = 1'b1;
    cyc = 0;
    while (!bus.req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    set_event(1'b1, 14'd242, 32'h00003000, 5'd0, 32'h0000001c, 32'h00000abc);
    got = ""; cyc = 0; finals = 0; hash_cyc = -100; caret2_cyc = -1;
    while (finals < 2 && cyc < 200) begin
      if (cyc == hash_cyc + 1) begin
        check("b2b_gap_valid", 32'(bus.char_valid), 32'd0);
        check("b2b_gap_char", 32'(bus.char), 32'h00);
      end
      if (bus.char_valid && bus.char_ready) begin
        if (bus.char == 8'h5E && finals == 1 && caret2_cyc < 0) begin
          caret2_cyc    = cyc;
          bus.req_valid = 1'b0;
        end
        got = $sformatf("%s%c", got, bus.char);
        if (bus.char == FINAL_CH) begin
          finals++;
          if (finals == 1) hash_cyc = cyc;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.req_valid = 1'b0;
    check_str("b2b_text", got, {s1, s2});
    check("b2b_caret_gap", 32'(caret2_cyc - hash_cyc), 32'd2);
    check("b2b_frame_cnt", 32'(frame_cnt), 32'd9);

    // Reset clears the count; then a frame is interrupted after its 10th transfer.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst2_frame_cnt", 32'(frame_cnt), 32'd0);
    set_event(1'b0, 14'd0, 32'h00000010, 5'd5, 32'h0, 32'hdeadbeef);
    offer("ir");
    cnt = 0; cyc = 0;
    while (cnt < 10 && cyc < 100) begin
      if (bus.char_valid && bus.char_ready) cnt++;
      if (cnt < 10) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("ir_ten_transfers", 32'(cnt), 32'd10);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("ir_char_valid", 32'(bus.char_valid), 32'd0);
    check("ir_char", 32'(bus.char), 32'h00);
    check("ir_frame_cnt", 32'(frame_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ir_req_ready", 32'(bus.req_ready), 32'd1);
    set_event(1'b0, 14'd12000, 32'hffffffff, 5'd0, 32'h0, 32'h0);
    offer("af");
    collect("af", 1'b0, got, span);
    check_str("af_text", got, s4);
    check("af_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
